// File: rtl/scheduler_pkg.sv
// Shared constants, FSM state type and small helpers for the note scheduler.
package scheduler_pkg;

  localparam logic [2:0] MODE_FREE  = 3'b100;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_LEARN = 3'b001;
  localparam logic [2:0] MODE_NONE  = 3'b000;

  localparam logic [3:0] NOTE_REST   = 4'd0;
  localparam logic [3:0] NOTE_MAX    = 4'd7;
  localparam logic [1:0] OCT_DEFAULT = 2'b01;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMute = 2'd1,
    StPlay = 2'd2
  } sched_state_e;

  // Exactly one of the three player switches set.
  function automatic logic mode_is_legal(input logic [2:0] m);
    return (m == MODE_FREE) || (m == MODE_AUTO) || (m == MODE_LEARN);
  endfunction

  // Codes above the last scale degree play as a rest.
  function automatic logic [3:0] clamp_note(input logic [3:0] n);
    return (n > NOTE_MAX) ? NOTE_REST : n;
  endfunction

endpackage

// File: rtl/mode_qualifier.sv
// Synchronises a raw multi-bit switch bank and accepts a value only after it has
// stayed unchanged for STABLE_CYCLES synchronised samples.
module mode_qualifier #(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_accepted,
  output logic             o_accept_pulse
);

  localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_accepted;
  logic             r_pulse;

  logic             w_chg;
  logic [CntW-1:0]  w_cnt_d;
  logic             w_hit;

  // Stability counter next state; saturates at CntLast, hit fires once per stable run.
  always_comb begin
    w_chg = (r_sync2 != r_prev);
    if (w_chg) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntLast) begin
      w_cnt_d = r_cnt;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
    w_hit = (w_cnt_d == CntLast) && (w_chg || (r_cnt != CntLast));
  end

  // Two-flop synchroniser, change detector, counter and accepted-value register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_cnt      <= '0;
      r_accepted <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_d;
      r_pulse <= w_hit;
      if (w_hit) begin
        r_accepted <= r_sync2;
      end
    end
  end

  assign o_accepted     = r_accepted;
  assign o_accept_pulse = r_pulse;

endmodule

// File: rtl/note_scheduler.sv
// Arbitrates the buzzer/LED datapath between the free, auto and learn players,
// inserting a silent gap on every change of grant.
module note_scheduler
  import scheduler_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES    = 2_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_mode,
  input  logic [3:0] i_free_note,
  input  logic [6:0] i_free_led,
  input  logic [1:0] i_free_octave,
  input  logic [3:0] i_auto_note,
  input  logic [6:0] i_auto_led,
  input  logic [1:0] i_auto_octave,
  input  logic [3:0] i_learn_note,
  input  logic [6:0] i_learn_led,
  input  logic [1:0] i_learn_octave,
  output logic [3:0] o_note,
  output logic [6:0] o_led,
  output logic [1:0] o_octave,
  output logic [2:0] o_active_src,
  output logic       o_switching,
  output logic       o_auto_run,
  output logic       o_learn_run
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  logic [2:0]   w_accepted;
  logic         w_accept_pulse;
  logic         w_legal;
  logic [2:0]   w_sel;
  logic [3:0]   w_src_note;
  logic [6:0]   w_src_led;
  logic [1:0]   w_src_oct;

  sched_state_e r_state;
  logic [2:0]   r_target;
  logic [GapW-1:0] r_gap_cnt;
  logic [2:0]   r_active;
  logic [3:0]   r_note;
  logic [6:0]   r_led;
  logic [1:0]   r_octave;
  logic         r_switching;
  logic         r_auto_run;
  logic         r_learn_run;

  mode_qualifier #(
    .WIDTH         (3),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_mode_qualifier (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_raw          (i_mode),
    .o_accepted     (w_accepted),
    .o_accept_pulse (w_accept_pulse)
  );

  assign w_legal = mode_is_legal(w_accepted);

  // While muted the pending target is what PLAY will load on entry.
  assign w_sel = (r_state == StPlay) ? r_active : r_target;

  // Source mux for the player currently selected.
  always_comb begin
    w_src_note = NOTE_REST;
    w_src_led  = '0;
    w_src_oct  = OCT_DEFAULT;
    unique case (w_sel)
      MODE_FREE: begin
        w_src_note = i_free_note;
        w_src_led  = i_free_led;
        w_src_oct  = i_free_octave;
      end
      MODE_AUTO: begin
        w_src_note = i_auto_note;
        w_src_led  = i_auto_led;
        w_src_oct  = i_auto_octave;
      end
      MODE_LEARN: begin
        w_src_note = i_learn_note;
        w_src_led  = i_learn_led;
        w_src_oct  = i_learn_octave;
      end
      default: begin
      end
    endcase
  end

  // Grant FSM with gap counter and registered outputs. Accepted mode only moves
  // together with the accept pulse, so decisions are taken on the pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_target    <= MODE_NONE;
      r_gap_cnt   <= '0;
      r_active    <= MODE_NONE;
      r_note      <= NOTE_REST;
      r_led       <= '0;
      r_octave    <= OCT_DEFAULT;
      r_switching <= 1'b0;
      r_auto_run  <= 1'b0;
      r_learn_run <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept_pulse && w_legal) begin
            r_state     <= StMute;
            r_target    <= w_accepted;
            r_gap_cnt   <= '0;
            r_switching <= 1'b1;
          end
        end
        StMute: begin
          if (w_accept_pulse && !w_legal) begin
            r_state     <= StIdle;
            r_target    <= MODE_NONE;
            r_gap_cnt   <= '0;
            r_switching <= 1'b0;
          end else if (w_accept_pulse && (w_accepted != r_target)) begin
            r_target  <= w_accepted;
            r_gap_cnt <= '0;
          end else if (r_gap_cnt == GapLast) begin
            r_state     <= StPlay;
            r_active    <= r_target;
            r_target    <= MODE_NONE;
            r_gap_cnt   <= '0;
            r_switching <= 1'b0;
            r_note      <= clamp_note(w_src_note);
            r_led       <= w_src_led;
            r_octave    <= w_src_oct;
            r_auto_run  <= (r_target == MODE_AUTO);
            r_learn_run <= (r_target == MODE_LEARN);
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        StPlay: begin
          if (w_accept_pulse && !w_legal) begin
            r_state     <= StIdle;
            r_active    <= MODE_NONE;
            r_note      <= NOTE_REST;
            r_led       <= '0;
            r_auto_run  <= 1'b0;
            r_learn_run <= 1'b0;
          end else if (w_accept_pulse && (w_accepted != r_active)) begin
            r_state     <= StMute;
            r_target    <= w_accepted;
            r_gap_cnt   <= '0;
            r_active    <= MODE_NONE;
            r_switching <= 1'b1;
            r_note      <= NOTE_REST;
            r_led       <= '0;
            r_auto_run  <= 1'b0;
            r_learn_run <= 1'b0;
          end else begin
            r_note   <= clamp_note(w_src_note);
            r_led    <= w_src_led;
            r_octave <= w_src_oct;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_note       = r_note;
  assign o_led        = r_led;
  assign o_octave     = r_octave;
  assign o_active_src = r_active;
  assign o_switching  = r_switching;
  assign o_auto_run   = r_auto_run;
  assign o_learn_run  = r_learn_run;

endmodule
